// File: rtl/punc_arb_pkg.sv
// Shared constants for the PUnC memory arbiter: arbitration states and
// read-return owner encodings.
package punc_arb_pkg;

    localparam logic ARB_OPEN      = 1'b0;
    localparam logic ARB_CORE_LOCK = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

endpackage

// File: rtl/punc_starve_counter.sv
// Saturating wait counter used by the arbiter's debug starvation guard.
// Only compiled when PUNC_ARB_STARVE_GUARD_EN is defined.
`ifdef PUNC_ARB_STARVE_GUARD_EN
module punc_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign at_limit = (count == CW'(LIMIT));

    // A clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/punc_mem_arbiter.sv
// Arbiter sharing PUnC's single-port synchronous memory between the core and
// a debug/loader port. Optional debug starvation guard: PUNC_ARB_STARVE_GUARD_EN.
module punc_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_lock,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import punc_arb_pkg::*;

    logic       state;
    logic [1:0] owner;
    logic       dbg_force;

`ifdef PUNC_ARB_STARVE_GUARD_EN
    logic starve_at_limit;

    punc_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (dbg_req & ~dbg_gnt),
        .clr      (dbg_gnt),
        .at_limit (starve_at_limit)
    );

    assign dbg_force = starve_at_limit & dbg_req;
`else
    logic unused_starve_cfg;

    assign unused_starve_cfg = ^STARVE_LIMIT;
    assign dbg_force         = 1'b0;
`endif

    // A locked core keeps the memory even while idle; the guard never breaks a lock.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst) begin
            if (state == ARB_CORE_LOCK) begin
                core_gnt = core_req;
            end else if (dbg_force) begin
                dbg_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    assign mem_en    = core_gnt | dbg_gnt;
    assign mem_we    = (core_gnt & core_we) | (dbg_gnt & dbg_we);
    assign mem_addr  = dbg_gnt ? dbg_addr  : core_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;

    assign core_rvalid = !rst && (owner == OWN_CORE);
    assign dbg_rvalid  = !rst && (owner == OWN_DBG);
    assign core_rdata  = mem_rdata;
    assign dbg_rdata   = mem_rdata;

    // Owner remembers who issued last cycle's read so the data is steered back to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_OPEN;
            owner <= OWN_NONE;
        end else begin
            if (state == ARB_OPEN && core_gnt && core_lock) begin
                state <= ARB_CORE_LOCK;
            end else if (state == ARB_CORE_LOCK && core_gnt && !core_lock) begin
                state <= ARB_OPEN;
            end

            if (core_gnt && !core_we) begin
                owner <= OWN_CORE;
            end else if (dbg_gnt && !dbg_we) begin
                owner <= OWN_DBG;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

endmodule
